stack_pointer_unit: RTL

STACK_POINTER_UNIT -- requirements
Module: stack_pointer_unit

---
 rtl/spu_pkg.sv | 14 +
 rtl/spu_stack_slice.sv | 105 ++++++++++
 rtl/stack_pointer_unit.sv | 56 +++++
 3 files changed

// File: rtl/spu_pkg.sv
// Shared types and default sizing for the stack pointer unit.
// Build option: define SPU_WATERMARK_EN to add the per-stack HiWater output.
package spu_pkg;

  localparam int SPU_ADDR_W  = 16;
  localparam int SPU_NUM_STK = 2;

  typedef enum logic [1:0] {
    SPU_RUN = 2'b00,
    SPU_OVF = 2'b01,
    SPU_UNF = 2'b10
  } spu_state_e;

endpackage

// File: rtl/spu_stack_slice.sv
// One independent stack: pointer register, RUN/OVF/UNF fault FSM, flags and,
// when SPU_WATERMARK_EN is defined, a high-water register.
module spu_stack_slice
  import spu_pkg::*;
#(
  parameter int              ADDR_W    = SPU_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE    = '0,
  parameter logic [ADDR_W-1:0] LIMIT   = '1,
  parameter logic            GROW_DOWN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              clr_fault,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] top_addr,
  output logic              empty,
  output logic              full,
  output logic [1:0]        fault
`ifdef SPU_WATERMARK_EN
  ,
  output logic [ADDR_W-1:0] hi_water
`endif
);

  spu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] sp_inc, sp_dec, sp_to_limit, sp_to_base;
  logic              pushed;

  assign sp_inc      = sp_q + ADDR_W'(1);
  assign sp_dec      = sp_q - ADDR_W'(1);
  assign sp_to_limit = GROW_DOWN ? sp_dec : sp_inc;
  assign sp_to_base  = GROW_DOWN ? sp_inc : sp_dec;

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    pushed  = 1'b0;
    if (load) begin
      sp_d = load_val;
    end else if (state_q == SPU_RUN) begin
      if (push && pop) begin
        // Replace-top keeps SP; there is no top to replace on an empty stack.
        if (empty) state_d = SPU_UNF;
      end else if (push) begin
        if (full) begin
          state_d = SPU_OVF;
        end else begin
          sp_d   = sp_to_limit;
          pushed = 1'b1;
        end
      end else if (pop) begin
        if (empty) state_d = SPU_UNF;
        else       sp_d    = sp_to_base;
      end
    end
    if (clr_fault) state_d = SPU_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SPU_RUN;
      sp_q    <= BASE;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
    end
  end

  assign sp       = sp_q;
  assign top_addr = sp_to_base;
  assign empty    = (sp_q == BASE);
  assign full     = (sp_q == LIMIT);
  assign fault    = state_q;

`ifdef SPU_WATERMARK_EN
  logic [ADDR_W-1:0] hw_q, hw_d;
  logic [ADDR_W-1:0] dist_new, dist_hw;

  // Depth measured from BASE in the growth direction, modulo 2^ADDR_W.
  assign dist_new = GROW_DOWN ? (BASE - sp_d) : (sp_d - BASE);
  assign dist_hw  = GROW_DOWN ? (BASE - hw_q) : (hw_q - BASE);

  always_comb begin
    hw_d = hw_q;
    if (clr_fault)                        hw_d = sp_q;
    else if (pushed && dist_new > dist_hw) hw_d = sp_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hw_q <= BASE;
    else        hw_q <= hw_d;
  end

  assign hi_water = hw_q;
`else
  logic unused_pushed;
  assign unused_pushed = pushed;
`endif

endmodule

// File: rtl/stack_pointer_unit.sv
// NUM_STK independent hardware stack pointers with sticky overflow/underflow state.
// Build option: define SPU_WATERMARK_EN to add the HiWater output.
module stack_pointer_unit
  import spu_pkg::*;
#(
  parameter int                          ADDR_W    = SPU_ADDR_W,
  parameter int                          NUM_STK   = SPU_NUM_STK,
  parameter logic [NUM_STK*ADDR_W-1:0]   BASE      = {16'h7FFF, 16'h0000},
  parameter logic [NUM_STK*ADDR_W-1:0]   LIMIT     = {16'h4000, 16'h3FFF},
  parameter logic [NUM_STK-1:0]          GROW_DOWN = 2'b10
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_STK-1:0]        Push,
  input  logic [NUM_STK-1:0]        Pop,
  input  logic [NUM_STK-1:0]        Load,
  input  logic [ADDR_W-1:0]         LoadVal,
  input  logic [NUM_STK-1:0]        ClrFault,
  output logic [NUM_STK*ADDR_W-1:0] SPOut,
  output logic [NUM_STK*ADDR_W-1:0] TopAddr,
  output logic [NUM_STK-1:0]        Empty,
  output logic [NUM_STK-1:0]        Full,
  output logic [NUM_STK*2-1:0]      Fault
`ifdef SPU_WATERMARK_EN
  ,
  output logic [NUM_STK*ADDR_W-1:0] HiWater
`endif
);

  for (genvar i = 0; i < NUM_STK; i++) begin : g_stk
    spu_stack_slice #(
      .ADDR_W    (ADDR_W),
      .BASE      (BASE[i*ADDR_W +: ADDR_W]),
      .LIMIT     (LIMIT[i*ADDR_W +: ADDR_W]),
      .GROW_DOWN (GROW_DOWN[i])
    ) u_slice (
      .clk       (CLK),
      .rst_n     (RST_N),
      .push      (Push[i]),
      .pop       (Pop[i]),
      .load      (Load[i]),
      .load_val  (LoadVal),
      .clr_fault (ClrFault[i]),
      .sp        (SPOut[i*ADDR_W +: ADDR_W]),
      .top_addr  (TopAddr[i*ADDR_W +: ADDR_W]),
      .empty     (Empty[i]),
      .full      (Full[i]),
      .fault     (Fault[i*2 +: 2])
`ifdef SPU_WATERMARK_EN
      ,
      .hi_water  (HiWater[i*ADDR_W +: ADDR_W])
`endif
    );
  end

endmodule
